// File: rtl/fir_mac_seq.sv
// Sequential FIR multiply-accumulate: one signed DWxDW product per cycle over a tap snapshot.
// Optional output saturation is enabled by defining FIR_OUT_SAT_EN (default: two's complement wrap).
module fir_mac_seq #(
    parameter int unsigned NTAPS     = 15,
    parameter int unsigned DW        = 16,
    parameter int unsigned ACCW      = 36,
    parameter int unsigned OUT_SHIFT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [NTAPS*DW-1:0] taps_in,
    input  logic                coef_we,
    input  logic [3:0]          coef_addr,
    input  logic [DW-1:0]       coef_data,
    output logic [DW-1:0]       y_out,
    output logic                y_valid,
    output logic                busy,
    output logic                overrun
);

    localparam int unsigned IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StOut
    } state_t;

    state_t state_q, state_d;

    logic signed [DW-1:0]   snap_q [NTAPS];
    logic signed [DW-1:0]   coef_q [NTAPS];
    logic signed [ACCW-1:0] acc_q;
    logic        [IW-1:0]   idx_q;
    logic        [DW-1:0]   y_out_q;
    logic                   y_valid_q;
    logic                   overrun_q;

    logic                   accept;
    logic                   last;
    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] acc_sum;
    logic signed [ACCW-1:0] shifted;
    logic        [DW-1:0]   y_red;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sample_valid) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (idx_q == IW'(NTAPS - 1)) begin
                    last    = 1'b1;
                    state_d = StOut;
                end
            end
            StOut: begin
                if (sample_valid) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The final tap's sum is reduced directly so y_valid lands in the OUT cycle.
    always_comb begin
        prod    = snap_q[idx_q] * coef_q[idx_q];
        acc_sum = acc_q + {{(ACCW - 2*DW){prod[2*DW-1]}}, prod};
        shifted = acc_sum >>> OUT_SHIFT;
`ifdef FIR_OUT_SAT_EN
        if (!shifted[ACCW-1] && (|shifted[ACCW-2:DW-1])) begin
            y_red = {1'b0, {(DW-1){1'b1}}};
        end else if (shifted[ACCW-1] && !(&shifted[ACCW-2:DW-1])) begin
            y_red = {1'b1, {(DW-1){1'b0}}};
        end else begin
            y_red = shifted[DW-1:0];
        end
`else
        y_red = shifted[DW-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            idx_q     <= '0;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < int'(NTAPS); i++) begin
                snap_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            y_valid_q <= last;
            if (last) begin
                y_out_q <= y_red;
            end
            if (state_q == StRun) begin
                acc_q <= acc_sum;
                idx_q <= idx_q + IW'(1);
                if (sample_valid) begin
                    overrun_q <= 1'b1;
                end
            end
            if (accept) begin
                acc_q <= '0;
                idx_q <= '0;
                for (int i = 0; i < int'(NTAPS); i++) begin
                    snap_q[i] <= taps_in[DW*i +: DW];
                end
            end
            if (coef_we && (state_q == StIdle) && (32'(coef_addr) < NTAPS)) begin
                coef_q[IW'(coef_addr)] <= coef_data;
            end
        end
    end

    assign y_out   = y_out_q;
    assign y_valid = y_valid_q;
    assign busy    = (state_q != StIdle);
    assign overrun = overrun_q;

endmodule

// File: doc/fir_mac_seq.md
Name: fir_mac_seq

Overview:
Sequential multiply-accumulate stage directly downstream of the 15-tap sample delay line. Snapshots the flat 240-bit tap vector when a new sample has been shifted in. Computes one FIR output by iterating a single signed 16x16 multiplier over the taps against a locally held coefficient bank. Presents the result with a one-cycle valid strobe.

Parameters:
NTAPS, 15, number of taps / coefficients
DW, 16, sample and coefficient width (signed two's complement)
ACCW, 36, accumulator width; must be >= 2*DW + ceil(log2(NTAPS))
OUT_SHIFT, 15, arithmetic right shift applied to the accumulator to form y_out (Q15 coefficients)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
sample_valid  input  1  one-cycle strobe: taps_in holds a freshly shifted sample set
taps_in  input  NTAPS*DW  tap vector from the delay line; tap i = bits [DW*i+DW-1 : DW*i], tap 0 newest
coef_we  input  1  coefficient write enable
coef_addr  input  4  coefficient index
coef_data  input  DW  signed coefficient value
y_out  output  DW  filtered sample
y_valid  output  1  one-cycle strobe, y_out updated this cycle
busy  output  1  high while a computation is in progress
overrun  output  1  sticky: a sample_valid was dropped

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset:
  - y_out=0, y_valid=0, busy=0, overrun=0.
  - All coefficients = 0; state = IDLE; accumulator = 0; tap index = 0.
- FSM states: IDLE, RUN, OUT.
- IDLE:
  - On sample_valid, latch taps_in into an internal snapshot, clear the accumulator, set index=0, go to RUN.
- RUN (busy=1):
  - Each cycle: acc += sext(snap[index]) * sext(coef[index]), using a full-precision signed 2*DW product sign-extended to ACCW; then index++.
  - After index NTAPS-1 is processed, go to OUT.
  - Exactly NTAPS RUN cycles.
- OUT (busy=1 for the cycle in which y_out/y_valid are registered; y_valid=1 in the following cycle):
  - Register y_out = (acc >>> OUT_SHIFT) reduced to DW bits (see Optional Feature) and pulse y_valid.
  - If sample_valid is present in this cycle, accept it exactly as in IDLE and go to RUN.
  - Otherwise go to IDLE.
- Latency: sample_valid accepted in cycle 0 -> y_valid high in cycle NTAPS+1 (16 by default). Minimum accepted sample spacing is NTAPS+1 cycles.
- y_out holds its value between strobes. y_valid is never high for two consecutive cycles.
- sample_valid during RUN:
  - The sample is dropped and overrun is set.
  - The in-progress computation and its result are unaffected.
  - overrun clears only on reset.
- Coefficient writes:
  - Accepted only when busy=0 and the FSM is in IDLE.
  - coef_we while busy=1 is ignored.
  - coef_addr >= NTAPS is ignored.
  - A write in the same cycle as an accepted sample_valid takes effect before tap 0 is multiplied.
- Reset mid-operation: abandon the computation, return to IDLE; no y_valid is produced for the abandoned sample.
- Snapshot isolation: taps_in changes after acceptance do not affect the result.

Optional Feature:
- Macro FIR_OUT_SAT_EN.
- Defined: the shifted accumulator is clamped to [-2^(DW-1), 2^(DW-1)-1], i.e. 0x8000..0x7FFF.
- Undefined: the low DW bits of the shifted accumulator are taken (two's complement wrap).
- Accumulator width and behaviour are identical in both builds.

Test Plan:
- Reset: assert reset for 2 cycles -> y_out=0x0000, y_valid=0, busy=0, overrun=0. Pulse sample_valid with no coefficients written -> y_valid at cycle 16 with y_out=0x0000.
- Single-tap impulse: coef[0]=0x7FFF, others 0; tap0=0x1000, others 0; pulse sample_valid at cycle 0 -> busy high cycles 1-16, y_valid exactly at cycle 16, y_out=0x0FFF.
- Uniform average: all coefs=0x4000, all taps=0x0100 -> y_out=0x0780. Repeat with all taps=0xFF00 (-256) -> y_out=0xF880.
- Overflow: all coefs=0x7FFF, all taps=0x7FFF -> shifted accumulator=0x77FE2. y_out=0x7FFF with FIR_OUT_SAT_EN defined; y_out=0x7FE2 without.
- Overrun/back-to-back:
  - Second sample_valid at cycle 5 -> dropped, overrun=1, first result unchanged at cycle 16.
  - sample_valid in the OUT cycle -> accepted, next y_valid 16 cycles later.
- Coef write while busy (coef_addr=0, 0x1234 during RUN) -> ignored, result unchanged; write to addr 15 -> ignored. reset asserted at cycle 8 of RUN -> no y_valid, busy=0 next cycle, coefficients cleared.
